// File: rtl/div_iter.sv
// ============================================================================
// Module   : div_iter
// Brief    : Iterative restoring shift-subtract divider for the EX stage.
//            Executes DIV/DIVU and returns {remainder, quotient} for HI/LO.
//            Resolves STEP quotient bits per cycle over WIDTH/STEP cycles.
// Options  : `define DIV_ANNUL_EN adds the annul_i port, which aborts an
//            in-flight division (ZERO or ON) back to FREE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
`ifdef DIV_ANNUL_EN
  input  logic               annul_i,
`endif
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div0_o
);

  // Iteration count and a counter wide enough to hold it.
  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  // FSM encoding.
  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_ZERO = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q;
  // Work register: {partial remainder (WIDTH+1 bits), dividend/quotient}.
  logic [2*WIDTH:0]   work_q;
  logic [WIDTH-1:0]   divisor_q;
  logic               q_neg_q;
  logic               r_neg_q;
  logic               div0_q;
  logic [2*WIDTH-1:0] result_q;

  logic               annul;
  logic               last_iter;
  logic [2*WIDTH:0]   work_step;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quot_mag;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   op1_mag;
  logic [WIDTH-1:0]   op2_mag;

`ifdef DIV_ANNUL_EN
  assign annul = annul_i;
`else
  assign annul = 1'b0;
`endif

  assign last_iter = (cnt_q == CW'(N - 1));

  // Operand magnitudes; -2^(WIDTH-1) negates to itself, read as unsigned.
  assign op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? (WIDTH'(0) - opdata1_i) : opdata1_i;
  assign op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? (WIDTH'(0) - opdata2_i) : opdata2_i;

  // One cycle of STEP restoring trial subtractions on the work register.
  always_comb begin
    work_step = work_q;
    trial     = '0;
    for (int s = 0; s < STEP; s++) begin
      work_step = {work_step[2*WIDTH-1:0], 1'b0};
      trial     = work_step[2*WIDTH:WIDTH] - {1'b0, divisor_q};
      // MSB clear means the partial remainder was >= divisor: keep the difference.
      if (!trial[WIDTH]) begin
        work_step[2*WIDTH:WIDTH] = trial;
        work_step[0]             = 1'b1;
      end
    end
  end

  // Sign fix-up: quotient sign is s1^s2, remainder follows the dividend.
  assign quot_mag = work_step[WIDTH-1:0];
  assign rem_mag  = work_step[2*WIDTH-1:WIDTH];
  assign quot_fix = q_neg_q ? (WIDTH'(0) - quot_mag) : quot_mag;
  assign rem_fix  = r_neg_q ? (WIDTH'(0) - rem_mag)  : rem_mag;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FREE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FREE: begin
        if (start_i) begin
          state_d = (opdata2_i == '0) ? ST_ZERO : ST_ON;
        end
      end
      ST_ZERO: begin
        state_d = annul ? ST_FREE : ST_DONE;
      end
      ST_ON: begin
        if (annul) begin
          state_d = ST_FREE;
        end else if (last_iter) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!start_i) begin
          state_d = ST_FREE;
        end
      end
      default: state_d = ST_FREE;
    endcase
  end

  // Output decode; div0 is only reported alongside ready.
  always_comb begin
    ready_o = (state_q == ST_DONE);
    busy_o  = (state_q == ST_ZERO) || (state_q == ST_ON);
    div0_o  = (state_q == ST_DONE) && div0_q;
  end

  assign result_o = result_q;

  // Datapath: operand capture, iteration and result registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      div0_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        ST_FREE: begin
          if (start_i) begin
            cnt_q     <= '0;
            work_q    <= {{(WIDTH+1){1'b0}}, op1_mag};
            divisor_q <= op2_mag;
            q_neg_q   <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_neg_q   <= signed_div_i && opdata1_i[WIDTH-1];
            div0_q    <= (opdata2_i == '0);
          end
        end
        ST_ZERO: begin
          // Result is cleared only on the way into DONE so an abort leaves it intact.
          if (!annul) begin
            result_q <= '0;
          end
        end
        ST_ON: begin
          work_q <= work_step;
          cnt_q  <= cnt_q + CW'(1);
          if (last_iter && !annul) begin
            result_q <= {rem_fix, quot_fix};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_iter.sv
// ============================================================================
// Module   : tb_div_iter
// Brief    : Directed self-checking bench for div_iter (WIDTH=32, STEP=1 and
//            STEP=2 instances). Build with DIV_ANNUL_EN to exercise annul_i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        start1;
  logic        start2;
  logic [63:0] res1, res2;
  logic        rdy1, rdy2, busy1, busy2, dz1, dz2;
`ifdef DIV_ANNUL_EN
  logic        annul;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op_a),
    .opdata2_i    (op_b),
    .start_i      (start1),
`ifdef DIV_ANNUL_EN
    .annul_i      (annul),
`endif
    .result_o     (res1),
    .ready_o      (rdy1),
    .busy_o       (busy1),
    .div0_o       (dz1)
  );

  div_iter #(.WIDTH(32), .STEP(2)) u_dut2 (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op_a),
    .opdata2_i    (op_b),
    .start_i      (start2),
`ifdef DIV_ANNUL_EN
    .annul_i      (1'b0),
`endif
    .result_o     (res2),
    .ready_o      (rdy2),
    .busy_o       (busy2),
    .div0_o       (dz2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Run one division on the selected instance, scrambling operands while it
  // runs, then hold start for 'hold' cycles past ready and release it.
  task automatic run_div(input string tag, input bit sel, input bit sgn,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eq, input logic [31:0] er,
                         input bit ed0, input int elat, input int hold);
    int cyc;
    bit got;
    logic [63:0] eres;
    eres = {er, eq};
    @(negedge clk);
    signed_div = sgn;
    op_a       = x;
    op_b       = y;
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) check({tag, " busy"}, sel ? busy2 : busy1, 64'd1);
      op_a       = $urandom;
      op_b       = $urandom;
      signed_div = ~signed_div;
      if (sel ? rdy2 : rdy1) got = 1'b1;
    end
    check({tag, " latency"}, 64'(cyc), 64'(elat));
    check({tag, " result"}, sel ? res2 : res1, eres);
    check({tag, " div0"}, sel ? dz2 : dz1, 64'(ed0));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, " hold ready"}, sel ? rdy2 : rdy1, 64'd1);
      check({tag, " hold result"}, sel ? res2 : res1, eres);
      check({tag, " hold div0"}, sel ? dz2 : dz1, 64'(ed0));
    end
    @(negedge clk);
    if (sel) start2 = 1'b0; else start1 = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " free ready"}, sel ? rdy2 : rdy1, 64'd0);
    check({tag, " free div0"}, sel ? dz2 : dz1, 64'd0);
    check({tag, " free result"}, sel ? res2 : res1, eres);
    check({tag, " free busy"}, sel ? busy2 : busy1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    signed_div = 1'b0;
    op_a       = '0;
    op_b       = '0;
    start1     = 1'b0;
    start2     = 1'b0;
`ifdef DIV_ANNUL_EN
    annul      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset result", res1, 64'd0);
    check("reset ready", rdy1, 64'd0);
    check("reset busy", busy1, 64'd0);
    check("reset div0", dz1, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic unsigned, held start for 5 cycles past ready.
    run_div("divu 100/7", 1'b0, 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0, 33, 5);
    // Signed sign fix-ups.
    run_div("div -7/2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33, 0);
    run_div("div 7/-2", 1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 33, 0);
    run_div("div -100/-7", 1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE, 1'b0, 33, 1);
    // Divide by zero.
    run_div("divu 5/0", 1'b0, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 2, 2);
    // Most-negative corner and its unsigned counterpart.
    run_div("div min/-1", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 33, 0);
    run_div("divu 8000/ffff", 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33, 0);
    run_div("divu ffff/1", 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 33, 0);
    run_div("divu hex", 1'b0, 1'b0, 32'h12345678, 32'h00001000, 32'h00012345, 32'h00000678, 1'b0, 33, 0);
    // Radix-4 instance.
    run_div("s2 divu 100/7", 1'b1, 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0, 17, 1);
    run_div("s2 div -7/2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 17, 0);
    run_div("s2 divu hex", 1'b1, 1'b0, 32'h12345678, 32'h00001000, 32'h00012345, 32'h00000678, 1'b0, 17, 0);
    run_div("divu 3/5", 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'd3, 1'b0, 33, 0);

`ifdef DIV_ANNUL_EN
    // Abort at cycle 10: no ready, result keeps {3, 0} from the previous division.
    @(negedge clk);
    signed_div = 1'b0;
    op_a       = 32'd100;
    op_b       = 32'd7;
    start1     = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("annul pre busy", busy1, 64'd1);
    @(negedge clk);
    annul  = 1'b1;
    start1 = 1'b0;
    @(posedge clk);
    #1;
    check("annul busy", busy1, 64'd0);
    @(negedge clk);
    annul = 1'b0;
    begin
      bit seen_ready;
      seen_ready = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk);
        #1;
        if (rdy1) seen_ready = 1'b1;
      end
      check("annul no ready", 64'(seen_ready), 64'd0);
    end
    check("annul result kept", res1, {32'd3, 32'd0});
    run_div("after annul", 1'b0, 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0, 33, 0);
`endif

    // Reset at cycle 10 of a division: everything back to zero.
    @(negedge clk);
    signed_div = 1'b0;
    op_a       = 32'd100;
    op_b       = 32'd7;
    start1     = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst pre busy", busy1, 64'd1);
    @(negedge clk);
    rst    = 1'b1;
    start1 = 1'b0;
    @(posedge clk);
    #1;
    check("rst result", res1, 64'd0);
    check("rst ready", rdy1, 64'd0);
    check("rst busy", busy1, 64'd0);
    check("rst div0", dz1, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("rst stays idle", rdy1, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
